tile_ram_arbiter: RTL and testbench

//  Shares the single-port maze tile RAM between the VGA scan-out and the game logic.

---
 rtl/tile_ram_arbiter.sv | 140 ++++++++++++++
 tb/tb_tile_ram_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_ram_arbiter.sv
// ============================================================================
// Module   : tile_ram_arbiter
// Brief    : Shares the single-port maze tile RAM between VGA tile prefetch
//            (fixed slot per 8-pixel tile) and game-logic req/ack accesses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tile_ram_arbiter #(
  parameter int X_SIZE   = 1650,
  parameter int Y_SIZE   = 750,
  parameter int X_PIXELS = 1280,
  parameter int Y_PIXELS = 720,
  parameter int TILES_X  = 160,
  parameter int ADDR_W   = 14,
  parameter int DATA_W   = 8
) (
  input  logic              vga_clk_i,
  input  logic              rst_i,
  input  logic [10:0]       pix_x_i,
  input  logic [9:0]        pix_y_i,
  output logic [DATA_W-1:0] scan_tile_o,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_ack_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i
);

  localparam logic [10:0]       c_X_ACT_END = 11'(X_PIXELS - 8);
  localparam logic [10:0]       c_X_PRE     = 11'(X_SIZE - 8);
  localparam logic [10:0]       c_X_LAST    = 11'(X_SIZE - 1);
  localparam logic [9:0]        c_Y_ACT     = 10'(Y_PIXELS);
  localparam logic [9:0]        c_Y_LAST    = 10'(Y_SIZE - 1);
  localparam logic [ADDR_W-1:0] c_TILES_X   = ADDR_W'(TILES_X);

  localparam logic [0:0] c_IDLE = 1'b0;
  localparam logic [0:0] c_RESP = 1'b1;

  logic [0:0]        r_state;
  logic [0:0]        w_next;
  logic              r_resp_we;
  logic              r_vslot_d;
  logic [DATA_W-1:0] r_prefetch;

  logic [9:0]        w_ny;
  logic              w_inline;
  logic              w_linestart;
  logic              w_vslot;
  logic              w_load;
  logic              w_issue;
  logic [ADDR_W-1:0] w_row;
  logic [ADDR_W-1:0] w_col;
  logic [ADDR_W-1:0] w_vaddr;

  // Slot decode: each tile's code is fetched one tile ahead of its first pixel.
  assign w_ny        = (pix_y_i == c_Y_LAST) ? 10'd0 : pix_y_i + 10'd1;
  assign w_inline    = (pix_x_i[2:0] == 3'd0) && (pix_x_i < c_X_ACT_END) && (pix_y_i < c_Y_ACT);
  assign w_linestart = (pix_x_i == c_X_PRE) && (w_ny < c_Y_ACT);
  assign w_vslot     = w_inline || w_linestart;
  assign w_load      = ((pix_x_i[2:0] == 3'd7) && (pix_x_i < c_X_ACT_END) && (pix_y_i < c_Y_ACT))
                    || ((pix_x_i == c_X_LAST) && (w_ny < c_Y_ACT));

  assign w_row   = w_inline ? ADDR_W'(pix_y_i[9:3]) : ADDR_W'(w_ny[9:3]);
  assign w_col   = w_inline ? ADDR_W'(pix_x_i[10:3]) + ADDR_W'(1) : '0;
  assign w_vaddr = w_row * c_TILES_X + w_col;

  assign w_issue = (r_state == c_IDLE) && cpu_req_i && !w_vslot;

  always_ff @(posedge vga_clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= c_IDLE;
      r_resp_we <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_issue) begin
        r_resp_we <= cpu_we_i;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE:  if (w_issue) w_next = c_RESP;
      c_RESP:  w_next = c_IDLE;
      default: w_next = c_IDLE;
    endcase
  end

  // Video has priority; a RESP cycle may overlap a vslot since the RAM is pipelined.
  always_comb begin
    ram_en_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    cpu_ack_o   = 1'b0;
    cpu_rdata_o = '0;
    if (!rst_i) begin
      if (w_vslot) begin
        ram_en_o   = 1'b1;
        ram_addr_o = w_vaddr;
      end else if (w_issue) begin
        ram_en_o    = 1'b1;
        ram_we_o    = cpu_we_i;
        ram_addr_o  = cpu_addr_i;
        ram_wdata_o = cpu_wdata_i;
      end
      if (r_state == c_RESP) begin
        cpu_ack_o   = 1'b1;
        cpu_rdata_o = r_resp_we ? '0 : ram_rdata_i;
      end
    end
  end

  always_ff @(posedge vga_clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_vslot_d   <= 1'b0;
      r_prefetch  <= '0;
      scan_tile_o <= '0;
    end else begin
      r_vslot_d <= w_vslot;
      if (r_vslot_d) begin
        r_prefetch <= ram_rdata_i;
      end
      if (w_load) begin
        scan_tile_o <= r_prefetch;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tile_ram_arbiter.sv
// ============================================================================
// Module   : tb_tile_ram_arbiter
// Brief    : Directed vector bench for tile_ram_arbiter with a behavioural
//            1-cycle-latency tile RAM initialised to mem[a] = a[7:0].
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tile_ram_arbiter;

  logic        clk;
  logic        rst;
  logic [10:0] pix_x;
  logic [9:0]  pix_y;
  logic [7:0]  scan_tile;
  logic        cpu_req;
  logic        cpu_we;
  logic [13:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        ram_en;
  logic        ram_we;
  logic [13:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;

  int n_chk;
  int n_fail;

  logic [7:0] mem [0:16383];

  tile_ram_arbiter dut (
    .vga_clk_i   (clk),
    .rst_i       (rst),
    .pix_x_i     (pix_x),
    .pix_y_i     (pix_y),
    .scan_tile_o (scan_tile),
    .cpu_req_i   (cpu_req),
    .cpu_we_i    (cpu_we),
    .cpu_addr_i  (cpu_addr),
    .cpu_wdata_i (cpu_wdata),
    .cpu_ack_o   (cpu_ack),
    .cpu_rdata_o (cpu_rdata),
    .ram_en_o    (ram_en),
    .ram_we_o    (ram_we),
    .ram_addr_o  (ram_addr),
    .ram_wdata_o (ram_wdata),
    .ram_rdata_i (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = i[7:0];
    ram_rdata = 8'd0;
  end

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  typedef struct {
    int x; int y; logic req; logic we; int addr; int wdata;
    logic en; logic ewe; int eaddr; int ewdata; logic ack; int erdata;
  } vec_t;

  vec_t tbl[20];
  int   n_vec;

  function automatic vec_t mk(int x, int y, logic req, logic we, int addr, int wdata,
                              logic en, logic ewe, int eaddr, int ewdata, logic ack, int erdata);
    vec_t v;
    v.x = x; v.y = y; v.req = req; v.we = we; v.addr = addr; v.wdata = wdata;
    v.en = en; v.ewe = ewe; v.eaddr = eaddr; v.ewdata = ewdata; v.ack = ack; v.erdata = erdata;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at t=%0t", nm, act, act, exp, exp, $time);
    end
  endtask

  // One clock cycle: apply inputs just after the edge, return at the falling edge.
  task automatic cyc(input int x, input int y, input logic req, input logic we,
                     input int addr, input int wd);
    @(posedge clk);
    #1;
    pix_x     = 11'(x);
    pix_y     = 10'(y);
    cpu_req   = req;
    cpu_we    = we;
    cpu_addr  = 14'(addr);
    cpu_wdata = 8'(wd);
    @(negedge clk);
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst = 1'b1; pix_x = 11'd0; pix_y = 10'd0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 14'd0; cpu_wdata = 8'd0;

    // Reset held on a pixel that would otherwise be a vslot.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_scan_tile", int'(scan_tile), 0);
    chk("rst_ack",       int'(cpu_ack),   0);
    chk("rst_rdata",     int'(cpu_rdata), 0);
    chk("rst_ram_en",    int'(ram_en),    0);
    chk("rst_ram_we",    int'(ram_we),    0);
    chk("rst_ram_addr",  int'(ram_addr),  0);
    chk("rst_ram_wdata", int'(ram_wdata), 0);

    @(posedge clk);
    #1;
    rst = 1'b0; pix_x = 11'd100; pix_y = 10'd730;
    @(negedge clk);
    chk("post_rst_en",   int'(ram_en),    0);
    chk("post_rst_ack",  int'(cpu_ack),   0);
    chk("post_rst_tile", int'(scan_tile), 0);

    // Slot decode and basic CPU traffic, one record per cycle.
    n_vec = 0;
    tbl[n_vec++] = mk(   8,  16, 0, 0, 0,     0, 1, 0,   322,    0, 0,    0);
    tbl[n_vec++] = mk(   9,  16, 0, 0, 0,     0, 0, 0,     0,    0, 0,    0);
    tbl[n_vec++] = mk(1642,   7, 0, 0, 0,     0, 1, 0,   160,    0, 0,    0);
    tbl[n_vec++] = mk(1642, 749, 0, 0, 0,     0, 1, 0,     0,    0, 0,    0);
    tbl[n_vec++] = mk(1642, 719, 0, 0, 0,     0, 0, 0,     0,    0, 0,    0);
    tbl[n_vec++] = mk(1642, 718, 0, 0, 0,     0, 1, 0, 14240,    0, 0,    0);
    tbl[n_vec++] = mk(1264,   0, 0, 0, 0,     0, 1, 0,   159,    0, 0,    0);
    tbl[n_vec++] = mk(1272,   0, 0, 0, 0,     0, 0, 0,     0,    0, 0,    0);
    tbl[n_vec++] = mk(   0, 719, 0, 0, 0,     0, 1, 0, 14241,    0, 0,    0);
    tbl[n_vec++] = mk(   0, 720, 0, 0, 0,     0, 0, 0,     0,    0, 0,    0);
    tbl[n_vec++] = mk(1648,   0, 0, 0, 0,     0, 0, 0,     0,    0, 0,    0);
    tbl[n_vec++] = mk( 100, 730, 1, 0, 'h123, 0, 1, 0, 'h123,    0, 0,    0);
    tbl[n_vec++] = mk( 101, 730, 0, 0, 0,     0, 0, 0,     0,    0, 1, 'h23);
    tbl[n_vec++] = mk( 102, 730, 1, 1, 'h200, 'h77, 1, 1, 'h200, 'h77, 0, 0);
    tbl[n_vec++] = mk( 103, 730, 0, 0, 0,     0, 0, 0,     0,    0, 1,    0);
    tbl[n_vec++] = mk( 104, 730, 1, 0, 'h200, 0, 1, 0, 'h200,    0, 0,    0);
    tbl[n_vec++] = mk( 105, 730, 0, 0, 0,     0, 0, 0,     0,    0, 1, 'h77);
    tbl[n_vec++] = mk(  16,  16, 1, 0, 5,     0, 1, 0,   323,    0, 0,    0);
    tbl[n_vec++] = mk(  17,  16, 1, 0, 5,     0, 1, 0,     5,    0, 0,    0);
    tbl[n_vec++] = mk(  18,  16, 0, 0, 0,     0, 0, 0,     0,    0, 1,    5);

    for (int i = 0; i < n_vec; i++) begin
      cyc(tbl[i].x, tbl[i].y, tbl[i].req, tbl[i].we, tbl[i].addr, tbl[i].wdata);
      chk($sformatf("vec%0d_en", i),  int'(ram_en),  int'(tbl[i].en));
      chk($sformatf("vec%0d_ack", i), int'(cpu_ack), int'(tbl[i].ack));
      if (tbl[i].en) begin
        chk($sformatf("vec%0d_addr", i), int'(ram_addr), tbl[i].eaddr);
        chk($sformatf("vec%0d_we", i),   int'(ram_we),   int'(tbl[i].ewe));
        if (tbl[i].ewe) chk($sformatf("vec%0d_wdata", i), int'(ram_wdata), tbl[i].ewdata);
      end
      if (tbl[i].ack) chk($sformatf("vec%0d_rdata", i), int'(cpu_rdata), tbl[i].erdata);
    end
    cyc(19, 16, 0, 0, 0, 0);

    // In-line prefetch: tile (col 2, row 2) shown over pixels 16..23.
    for (int x = 0; x <= 24; x++) begin
      cyc(x, 16, 0, 0, 0, 0);
      if (x == 8) chk("line_addr_x8", int'(ram_addr), 322);
      if (x >= 16 && x <= 23) chk($sformatf("line_tile_x%0d", x), int'(scan_tile), 'h42);
    end

    // Line-start prefetch wrapping into the next row.
    for (int x = 1640; x <= 1649; x++) begin
      cyc(x, 7, 0, 0, 0, 0);
      if (x == 1642) chk("wrap_addr", int'(ram_addr), 160);
    end
    cyc(0, 8, 0, 0, 0, 0);
    chk("wrap_tile", int'(scan_tile), 'hA0);

    // CPU write deferred by a vslot, then read back.
    cyc(7, 16, 0, 0, 0, 0);
    cyc(8, 16, 1, 1, 'h100, 'h5A);
    chk("wr_vslot_we",  int'(ram_we),   0);
    chk("wr_vslot_ack", int'(cpu_ack),  0);
    cyc(9, 16, 1, 1, 'h100, 'h5A);
    chk("wr_issue_en",    int'(ram_en),    1);
    chk("wr_issue_we",    int'(ram_we),    1);
    chk("wr_issue_addr",  int'(ram_addr),  'h100);
    chk("wr_issue_wdata", int'(ram_wdata), 'h5A);
    cyc(10, 16, 1, 1, 'h100, 'h5A);
    chk("wr_ack",   int'(cpu_ack),   1);
    chk("wr_rdata", int'(cpu_rdata), 0);
    chk("wr_resp_en", int'(ram_en),  0);
    cyc(11, 16, 0, 0, 0, 0);
    chk("wr_ack_done", int'(cpu_ack), 0);
    cyc(12, 16, 1, 0, 'h100, 0);
    chk("rd_issue_addr", int'(ram_addr), 'h100);
    chk("rd_issue_we",   int'(ram_we),   0);
    cyc(13, 16, 1, 0, 'h100, 0);
    chk("rd_ack",   int'(cpu_ack),   1);
    chk("rd_rdata", int'(cpu_rdata), 'h5A);
    cyc(14, 16, 0, 0, 0, 0);

    // Vblank, request held: one access every second cycle, no video strobes.
    for (int i = 0; i < 8; i++) begin
      cyc(1640 + i, 730, 1, 0, 'hAB, 0);
      chk($sformatf("vb%0d_ack", i), int'(cpu_ack), (i % 2 == 1) ? 1 : 0);
      chk($sformatf("vb%0d_en", i),  int'(ram_en),  (i % 2 == 0) ? 1 : 0);
      if (i % 2 == 0) chk($sformatf("vb%0d_addr", i), int'(ram_addr), 'hAB);
      if (i % 2 == 1) chk($sformatf("vb%0d_rdata", i), int'(cpu_rdata), 'hAB);
    end
    cyc(1648, 730, 0, 0, 0, 0);

    // Reset during RESP: ack drops at once, the strobed write stays committed.
    cyc(300, 730, 1, 1, 'h300, 'h33);
    chk("rr_issue_we", int'(ram_we), 1);
    cyc(301, 730, 0, 0, 0, 0);
    chk("rr_ack_before", int'(cpu_ack), 1);
    #1;
    rst = 1'b1;
    #1;
    chk("rr_ack_in_rst", int'(cpu_ack), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(302, 730, 0, 0, 0, 0);
    chk("rr_idle_ack", int'(cpu_ack), 0);
    cyc(303, 730, 1, 0, 'h300, 0);
    chk("rr_rd_en",   int'(ram_en),   1);
    chk("rr_rd_addr", int'(ram_addr), 'h300);
    cyc(304, 730, 1, 0, 'h300, 0);
    chk("rr_rd_ack",   int'(cpu_ack),   1);
    chk("rr_rd_rdata", int'(cpu_rdata), 'h33);
    cyc(305, 730, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
